// File: rtl/ahb_bus_ctrl.sv
// rtl/ahb_bus_ctrl.sv - 4-master fixed-priority AHB arbiter with burst/lock/split awareness plus 4-slave decoder
module ahb_bus_ctrl (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HBUSREQx0,
  input  logic        HBUSREQx1,
  input  logic        HBUSREQx2,
  input  logic        HBUSREQx3,
  input  logic        HLOCKx0,
  input  logic        HLOCKx1,
  input  logic        HLOCKx2,
  input  logic        HLOCKx3,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HRESP,
  input  logic        HREADY,
  input  logic [3:0]  HSPLIT,
  output logic        HGRANTx0,
  output logic        HGRANTx1,
  output logic        HGRANTx2,
  output logic        HGRANTx3,
  output logic [3:0]  HMASTER,
  output logic [3:0]  HMASTERD,
  output logic        HMASTERLOCK,
  output logic        HSELx0,
  output logic        HSELx1,
  output logic        HSELx2,
  output logic        HSELx3
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] RESP_RETRY   = 2'b10;
  localparam logic [1:0] RESP_SPLIT   = 2'b11;

  logic [3:0] grant;
  logic [3:0] split_mask;
  logic [4:0] rem;
  logic       force_arb;
  logic [1:0] hmaster_idx;
  logic [1:0] hmasterd_idx;

  logic [3:0] req_vec;
  logic [3:0] lock_vec;
  logic [3:0] eligible;
  logic [3:0] winner;
  logic [1:0] granted_idx;
  logic       granted_lock;
  logic [4:0] rem_upd;
  logic       lock_cond;
  logic       abort_resp;
  logic       arb_point;
  logic [3:0] split_set;
  logic       unused_addr;

  assign req_vec  = {HBUSREQx3, HBUSREQx2, HBUSREQx1, HBUSREQx0};
  assign lock_vec = {HLOCKx3, HLOCKx2, HLOCKx1, HLOCKx0};
  assign eligible = req_vec & ~split_mask;

  assign {HGRANTx3, HGRANTx2, HGRANTx1, HGRANTx0} = grant;
  assign HMASTER  = {2'b00, hmaster_idx};
  assign HMASTERD = {2'b00, hmasterd_idx};

  // Slave decode straight from the top address nibble; regions 4..15 select nothing
  assign HSELx0 = (HADDR[31:28] == 4'd0);
  assign HSELx1 = (HADDR[31:28] == 4'd1);
  assign HSELx2 = (HADDR[31:28] == 4'd2);
  assign HSELx3 = (HADDR[31:28] == 4'd3);
  assign unused_addr = ^HADDR[27:0];

  // Fixed priority pick, highest index wins; master 0 parks the bus when nobody asks
  always_comb begin
    winner = 4'b0001;
    if (eligible[3])      winner = 4'b1000;
    else if (eligible[2]) winner = 4'b0100;
    else if (eligible[1]) winner = 4'b0010;
  end

  // Index and lock line of the master currently holding the grant
  always_comb begin
    granted_idx = 2'd0;
    case (grant)
      4'b0010: granted_idx = 2'd1;
      4'b0100: granted_idx = 2'd2;
      4'b1000: granted_idx = 2'd3;
      default: granted_idx = 2'd0;
    endcase
    granted_lock = lock_vec[granted_idx];
  end

  // Remaining-beat count as it would be after this edge's accepted address phase
  always_comb begin
    rem_upd = rem;
    case (HTRANS)
      TRANS_IDLE: rem_upd = 5'd0;
      TRANS_BUSY: rem_upd = rem;
      TRANS_NONSEQ: begin
        case (HBURST)
          3'd2, 3'd3: rem_upd = 5'd3;
          3'd4, 3'd5: rem_upd = 5'd7;
          3'd6, 3'd7: rem_upd = 5'd15;
          default:    rem_upd = 5'd0;
        endcase
      end
      TRANS_SEQ: rem_upd = (rem == 5'd0) ? 5'd0 : rem - 5'd1;
      default: rem_upd = rem;
    endcase
  end

  // A SPLIT/RETRY first cycle overrides both the burst count and any lock at the next ready edge
  assign lock_cond  = HMASTERLOCK && granted_lock;
  assign abort_resp = !HREADY && ((HRESP == RESP_SPLIT) || (HRESP == RESP_RETRY));
  assign arb_point  = HREADY && (force_arb || ((rem_upd == 5'd0) && !lock_cond));
  assign split_set  = (!HREADY && (HRESP == RESP_SPLIT)) ? (4'b0001 << hmasterd_idx) : 4'b0000;

  // Arbiter state: grant, ownership pipeline, burst count, split mask and pending re-arbitration
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant        <= 4'b0001;
      hmaster_idx  <= 2'd0;
      hmasterd_idx <= 2'd0;
      HMASTERLOCK  <= 1'b0;
      split_mask   <= 4'b0000;
      rem          <= 5'd0;
      force_arb    <= 1'b0;
    end else begin
      // Release beats set so a same-edge resume always unmasks
      split_mask <= (split_mask | split_set) & ~HSPLIT;
      if (HREADY) begin
        rem          <= rem_upd;
        force_arb    <= 1'b0;
        hmaster_idx  <= granted_idx;
        HMASTERLOCK  <= granted_lock;
        hmasterd_idx <= hmaster_idx;
        if (arb_point) begin
          grant <= winner;
        end
      end else if (abort_resp) begin
        rem       <= 5'd0;
        force_arb <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_bus_ctrl.sv
// tb/tb_ahb_bus_ctrl.sv - self-checking bench for ahb_bus_ctrl: vector tables, directed sequences, random vs reference model
module tb_ahb_bus_ctrl;

  logic        HCLK;
  logic        HRESETn;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [1:0]  HRESP;
  logic        HREADY;
  logic [3:0]  HSPLIT;
  logic [3:0]  gnt;
  logic [3:0]  HMASTER;
  logic [3:0]  HMASTERD;
  logic        HMASTERLOCK;
  logic [3:0]  sel;

  int checks = 0;
  int errors = 0;

  // reference model state (plain integers)
  bit model_on = 0;
  int m_gnt, m_hm, m_hmd, m_hml, m_rem;
  bit m_force;
  bit m_mask [4];

  ahb_bus_ctrl dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HBUSREQx0(req[0]), .HBUSREQx1(req[1]), .HBUSREQx2(req[2]), .HBUSREQx3(req[3]),
    .HLOCKx0(lock[0]), .HLOCKx1(lock[1]), .HLOCKx2(lock[2]), .HLOCKx3(lock[3]),
    .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HRESP(HRESP),
    .HREADY(HREADY), .HSPLIT(HSPLIT),
    .HGRANTx0(gnt[0]), .HGRANTx1(gnt[1]), .HGRANTx2(gnt[2]), .HGRANTx3(gnt[3]),
    .HMASTER(HMASTER), .HMASTERD(HMASTERD), .HMASTERLOCK(HMASTERLOCK),
    .HSELx0(sel[0]), .HSELx1(sel[1]), .HSELx2(sel[2]), .HSELx3(sel[3])
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct { logic [31:0] addr; logic [3:0] exp_sel; } dec_vec_t;
  typedef struct { logic [3:0] req; int exp_gnt; } pri_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_own(input string name, input int g, input int hm, input int hmd, input int hml);
    chk({name, ".grant"}, {28'd0, gnt}, 32'd1 << g);
    chk({name, ".hmaster"}, {28'd0, HMASTER}, g == g ? hm : 0);
    chk({name, ".hmasterd"}, {28'd0, HMASTERD}, hmd);
    chk({name, ".hmasterlock"}, {31'd0, HMASTERLOCK}, hml);
  endtask

  function automatic int beats(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [3:0] dec_model(input logic [31:0] a);
    int region = int'(a >> 28);
    return (region < 4) ? 4'(1 << region) : 4'b0000;
  endfunction

  task automatic model_reset();
    m_gnt = 0; m_hm = 0; m_hmd = 0; m_hml = 0; m_rem = 0; m_force = 0;
    for (int i = 0; i < 4; i++) m_mask[i] = 0;
  endtask

  // one rising edge as the rules describe it, using the inputs present before the edge
  task automatic model_edge();
    int win = 0;
    int nrem;
    bit arb;
    for (int i = 0; i < 4; i++) if (req[i] && !m_mask[i]) win = i;
    if (HREADY) begin
      case (HTRANS)
        2'b00:   nrem = 0;
        2'b01:   nrem = m_rem;
        2'b10:   nrem = beats(HBURST) - 1;
        default: nrem = (m_rem > 0) ? m_rem - 1 : 0;
      endcase
      arb = m_force || (nrem == 0 && !(m_hml == 1 && lock[m_gnt]));
      m_hmd = m_hm;
      m_hm = m_gnt;
      m_hml = lock[m_gnt];
      if (arb) m_gnt = win;
      m_rem = nrem;
      m_force = 0;
    end else if (HRESP == 2'b11 || HRESP == 2'b10) begin
      if (HRESP == 2'b11) m_mask[m_hmd] = 1;
      m_rem = 0;
      m_force = 1;
    end
    for (int i = 0; i < 4; i++) if (HSPLIT[i]) m_mask[i] = 0;
  endtask

  task automatic step();
    @(posedge HCLK);
    if (model_on) model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    req = 4'b0; lock = 4'b0; HTRANS = 2'b00; HBURST = 3'd0;
    HRESP = 2'b00; HREADY = 1'b1; HSPLIT = 4'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    HRESETn = 1'b0;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    model_reset();
  endtask

  dec_vec_t dec_tab [8];
  pri_vec_t pri_tab [8];

  initial begin
    HADDR = 32'h0;
    apply_reset();

    // reset state
    chk_own("reset", 0, 0, 0, 0);

    // decoder table
    dec_tab[0] = '{32'h0000_0000, 4'b0001};
    dec_tab[1] = '{32'h1000_0004, 4'b0010};
    dec_tab[2] = '{32'h2000_0010, 4'b0100};
    dec_tab[3] = '{32'h3FFF_FFFC, 4'b1000};
    dec_tab[4] = '{32'h4000_0000, 4'b0000};
    dec_tab[5] = '{32'hF000_0000, 4'b0000};
    dec_tab[6] = '{32'h0FFF_FFFF, 4'b0001};
    dec_tab[7] = '{32'h2FFF_FFFF, 4'b0100};
    for (int i = 0; i < 8; i++) begin
      HADDR = dec_tab[i].addr;
      #1;
      chk($sformatf("decode[%0d]", i), {28'd0, sel}, {28'd0, dec_tab[i].exp_sel});
    end

    // priority table, IDLE with HREADY=1 so every edge arbitrates
    pri_tab[0] = '{4'b0000, 0};
    pri_tab[1] = '{4'b0001, 0};
    pri_tab[2] = '{4'b0010, 1};
    pri_tab[3] = '{4'b0011, 1};
    pri_tab[4] = '{4'b0110, 2};
    pri_tab[5] = '{4'b1111, 3};
    pri_tab[6] = '{4'b1000, 3};
    pri_tab[7] = '{4'b0101, 2};
    for (int i = 0; i < 8; i++) begin
      req = pri_tab[i].req;
      step();
      chk($sformatf("priority[%0d]", i), {28'd0, gnt}, 32'd1 << pri_tab[i].exp_gnt);
    end

    // request-to-grant-to-owner pipeline
    apply_reset();
    req = 4'b1100;
    step(); chk_own("pipe_e1", 3, 0, 0, 0);
    step(); chk_own("pipe_e2", 3, 3, 0, 0);
    step(); chk_own("pipe_e3", 3, 3, 3, 0);

    // INCR4 by master 3, master 2 waits for last beat
    apply_reset();
    req = 4'b1000;
    step();
    req = 4'b0100; HTRANS = 2'b10; HBURST = 3'd3;
    step(); chk("burst_b1", {28'd0, gnt}, 32'h8);
    HTRANS = 2'b11;
    step(); chk("burst_b2", {28'd0, gnt}, 32'h8);
    step(); chk("burst_b3", {28'd0, gnt}, 32'h8);
    step(); chk("burst_b4", {28'd0, gnt}, 32'h4);

    // same burst with two wait states mid-burst
    apply_reset();
    req = 4'b1000;
    step();
    req = 4'b0100; HTRANS = 2'b10; HBURST = 3'd3;
    step(); chk("wburst_b1", {28'd0, gnt}, 32'h8);
    HTRANS = 2'b11;
    step(); chk("wburst_b2", {28'd0, gnt}, 32'h8);
    HREADY = 1'b0;
    step(); chk("wburst_w1", {28'd0, gnt}, 32'h8);
    step(); chk("wburst_w2", {28'd0, gnt}, 32'h8);
    HREADY = 1'b1;
    step(); chk("wburst_b3", {28'd0, gnt}, 32'h8);
    step(); chk("wburst_b4", {28'd0, gnt}, 32'h4);

    // locked SINGLE transfers from master 3
    apply_reset();
    req = 4'b1000; lock = 4'b1000;
    step(); chk_own("lock_e1", 3, 0, 0, 0);
    req = 4'b1100; HTRANS = 2'b10; HBURST = 3'd0;
    step(); chk_own("lock_e2", 3, 3, 0, 1);
    req = 4'b0100;
    step(); chk_own("lock_e3", 3, 3, 3, 1);
    step(); chk_own("lock_e4", 3, 3, 3, 1);
    lock = 4'b0000;
    step(); chk_own("lock_e5", 2, 3, 3, 0);

    // SPLIT of master 3, then resume
    apply_reset();
    req = 4'b1000;
    step(); step(); step();
    chk_own("split_own", 3, 3, 3, 0);
    req = 4'b1100; HREADY = 1'b0; HRESP = 2'b11;
    step(); chk_own("split_r1", 3, 3, 3, 0);
    HREADY = 1'b1;
    step(); chk_own("split_r2", 2, 3, 3, 0);
    HRESP = 2'b00;
    step(); chk("split_masked", {28'd0, gnt}, 32'h4);
    HSPLIT = 4'b1000;
    step(); chk("split_release_edge", {28'd0, gnt}, 32'h4);
    HSPLIT = 4'b0000;
    step(); chk("split_regrant", {28'd0, gnt}, 32'h8);

    // SPLIT with no other requester parks on master 0
    apply_reset();
    req = 4'b1000;
    step(); step(); step();
    HREADY = 1'b0; HRESP = 2'b11;
    step();
    HREADY = 1'b1;
    step(); chk("split_park", {28'd0, gnt}, 32'h1);

    // randomized run against the reference model, with a mid-operation reset
    apply_reset();
    model_on = 1;
    for (int n = 0; n < 400; n++) begin
      req    = 4'($urandom);
      lock   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      HTRANS = 2'($urandom);
      HBURST = 3'($urandom);
      HREADY = ($urandom_range(0, 3) != 0);
      HRESP  = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00;
      HSPLIT = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
      HADDR  = $urandom;
      step();
      chk("rnd.grant", {28'd0, gnt}, 32'd1 << m_gnt);
      chk("rnd.hmaster", {28'd0, HMASTER}, m_hm);
      chk("rnd.hmasterd", {28'd0, HMASTERD}, m_hmd);
      chk("rnd.hmasterlock", {31'd0, HMASTERLOCK}, m_hml);
      chk("rnd.hsel", {28'd0, sel}, {28'd0, dec_model(HADDR)});
      if (n == 200) begin
        HRESETn = 1'b0;
        #2;
        chk_own("midreset", 0, 0, 0, 0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        model_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
